// File: rtl/ysyx_23060191_ifu.sv
// ysyx_23060191 instruction fetch unit: owns the PC, fetches words from
// instruction memory and hands each instruction to decode with its address.
module ysyx_23060191_ifu #(
  parameter int CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 imem_req_valid,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_req_ready,
  input  logic                 imem_rsp_valid,
  input  logic [CPU_WIDTH-1:0] imem_rsp_data,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] pc,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc
);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t               state;
  logic [CPU_WIDTH-1:0] pc_r;
  logic [CPU_WIDTH-1:0] inst_r;
  logic [CPU_WIDTH-1:0] pc_out_r;
  logic                 drop_r;
  logic [CPU_WIDTH-1:0] tgt;

  assign tgt = {redirect_pc[CPU_WIDTH-1:2], 2'b00};

  // A redirect withdraws the request so the stale PC is never accepted.
  assign imem_req_valid = (state == REQ) && !redirect_valid && !rst;
  assign imem_req_addr  = {pc_r[CPU_WIDTH-1:2], 2'b00};
  assign inst_valid     = (state == HOLD) && !rst;
  assign inst           = inst_r;
  assign pc             = pc_out_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= REQ;
      pc_r     <= RESET_PC;
      drop_r   <= 1'b0;
      inst_r   <= '0;
      pc_out_r <= '0;
    end else begin
      case (state)
        REQ: begin
          if (redirect_valid) begin
            pc_r <= tgt;
          end else if (imem_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            pc_r <= tgt;
          end
          if (imem_rsp_valid) begin
            if (!drop_r && !redirect_valid) begin
              inst_r   <= imem_rsp_data;
              pc_out_r <= pc_r;
              state    <= HOLD;
            end else begin
              drop_r <= 1'b0;
              state  <= REQ;
            end
          end else if (redirect_valid) begin
            // The in-flight word belongs to the old path; eat it on arrival.
            drop_r <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_r  <= tgt;
            state <= REQ;
          end else if (inst_ready) begin
            pc_r  <= pc_r + CPU_WIDTH'(4);
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule
